// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle for pipe_stage_hs: upstream valid/ready/data and downstream valid/ready/data.
// master = environment side (drives upstream data and downstream ready), slave = the stage.
interface pipe_stage_hs_if #(
    parameter int unsigned WIDTH = 42
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline register with valid/ready handshake, synchronous flush and NOP bubbles.
// Optional second (skid) entry with registered in_ready when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_hs #(
    parameter int unsigned      WIDTH     = 42,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    pipe_stage_hs_if.slave hs,
    output logic [1:0]     occupancy
);

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic             accept;
    logic             pop;

    assign accept       = hs.in_valid & hs.in_ready;
    assign pop          = main_v_q & hs.out_ready;
    assign hs.out_valid = main_v_q;
    assign hs.out_data  = main_d_q;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;

    // in_ready depends only on held state plus flush/reset, never on out_ready.
    assign hs.in_ready = ~skid_v_q & ~flush & ~reset;
    assign occupancy   = {1'b0, main_v_q} + {1'b0, skid_v_q};

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = NOP_VALUE;
            skid_v_d = 1'b0;
            skid_d_d = NOP_VALUE;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d = 1'b1;
                main_d_d = hs.in_data;
            end
        end else if (pop) begin
            if (skid_v_q) begin
                main_d_d = skid_d_q;
                skid_v_d = 1'b0;
                skid_d_d = NOP_VALUE;
            end else if (accept) begin
                main_d_d = hs.in_data;
            end else begin
                main_v_d = 1'b0;
                main_d_d = NOP_VALUE;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d_d = hs.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_v_q <= 1'b0;
            skid_d_q <= NOP_VALUE;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end
`else
    // Single entry: a pop frees the slot in the same cycle, so refill without a bubble.
    assign hs.in_ready = (~main_v_q | hs.out_ready) & ~flush & ~reset;
    assign occupancy   = {1'b0, main_v_q};

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = NOP_VALUE;
        end else if (accept) begin
            main_v_d = 1'b1;
            main_d_d = hs.in_data;
        end else if (pop) begin
            main_v_d = 1'b0;
            main_d_d = NOP_VALUE;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q <= 1'b0;
            main_d_q <= NOP_VALUE;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and scoreboard bench for pipe_stage_hs; expectations adapt when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_hs;

    localparam int unsigned W   = 42;
    localparam logic [W-1:0] NOP = '0;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic         flush;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_ready;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic [1:0]   exp_occ;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    int         checks = 0;
    int         failures = 0;

    pipe_stage_hs_if #(.WIDTH(W)) hs ();

    pipe_stage_hs #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .hs        (hs),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
        flush        = fl;
        hs.in_valid  = iv;
        hs.in_data   = d;
        hs.out_ready = ordy;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] occ);
        chk({tag, ".out_valid"}, 64'(hs.out_valid), 64'(v));
        chk({tag, ".out_data"},  64'(hs.out_data),  64'(d));
        chk({tag, ".occupancy"}, 64'(occupancy),    64'(occ));
    endtask

    vec_t vecs[12];
    logic [W-1:0] q[$];

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, W'(5), 1'b0);
        #2;
        chk_out("reset", 1'b0, NOP, 2'd0);
        chk("reset.in_ready", 64'(hs.in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);

`ifndef PIPE_STAGE_SKID_EN
        vecs[0]  = '{1'b0, 1'b1, W'(1),            1'b0, 1'b1, 1'b1, W'(1),            2'd1};
        vecs[1]  = '{1'b0, 1'b1, W'(2),            1'b1, 1'b1, 1'b1, W'(2),            2'd1};
        vecs[2]  = '{1'b0, 1'b1, W'(3),            1'b0, 1'b0, 1'b1, W'(2),            2'd1};
        vecs[3]  = '{1'b0, 1'b0, W'(0),            1'b0, 1'b0, 1'b1, W'(2),            2'd1};
        vecs[4]  = '{1'b0, 1'b0, W'(0),            1'b1, 1'b1, 1'b0, NOP,              2'd0};
        vecs[5]  = '{1'b0, 1'b0, W'(0),            1'b0, 1'b1, 1'b0, NOP,              2'd0};
        vecs[6]  = '{1'b0, 1'b1, W'(42'h2A),       1'b0, 1'b1, 1'b1, W'(42'h2A),       2'd1};
        vecs[7]  = '{1'b1, 1'b1, W'(42'h55),       1'b0, 1'b0, 1'b0, NOP,              2'd0};
        vecs[8]  = '{1'b0, 1'b1, {W{1'b1}},        1'b1, 1'b1, 1'b1, {W{1'b1}},        2'd1};
        vecs[9]  = '{1'b1, 1'b0, W'(0),            1'b1, 1'b0, 1'b0, NOP,              2'd0};
        vecs[10] = '{1'b1, 1'b1, W'(7),            1'b0, 1'b0, 1'b0, NOP,              2'd0};
        vecs[11] = '{1'b0, 1'b1, W'(42'h2AAAAAAAAAA), 1'b1, 1'b1, 1'b1, W'(42'h2AAAAAAAAAA), 2'd1};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 64'(hs.in_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_occ);
        end
`endif

        // Reset asserted asynchronously while an entry is held.
        @(negedge clk);
        drive(1'b0, 1'b1, W'(9), 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid.loaded", 64'(hs.out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, NOP, 2'd0);
        chk("rst_mid.in_ready", 64'(hs.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk_out("rst_hold", 1'b0, NOP, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, W'(i), 1'b1);
            @(posedge clk);
            #1;
            chk_out($sformatf("stream%0d", i), 1'b1, W'(i), 2'd1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("stream_drain", 1'b0, NOP, 2'd0);

        // Stall with 0x2A held, 0x2B offered upstream.
        @(negedge clk);
        drive(1'b0, 1'b1, W'(42'h2A), 1'b1);
        @(posedge clk);
        #1;
        chk_out("stall_load", 1'b1, W'(42'h2A), 2'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, W'(42'h2B), 1'b0);
            @(posedge clk);
            #1;
            chk_out($sformatf("stall%0d", i), 1'b1, W'(42'h2A), SKID ? 2'd2 : 2'd1);
            chk($sformatf("stall%0d.in_ready", i), 64'(hs.in_ready), 64'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, W'(42'h2B), 1'b1);
        @(posedge clk);
        #1;
        chk_out("release", 1'b1, W'(42'h2B), 2'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("release_drain", 1'b0, NOP, 2'd0);

        // Flush with the stage full; 0x55 offered in the flush cycle must be dropped.
        @(negedge clk);
        drive(1'b0, 1'b1, W'(42'h11), 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, W'(42'h22), 1'b0);
        @(posedge clk);
        #1;
        chk_out("pre_flush", 1'b1, W'(42'h11), SKID ? 2'd2 : 2'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, W'(42'h55), 1'b0);
        #1;
        chk("flush.in_ready", 64'(hs.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk_out("flush", 1'b0, NOP, 2'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("post_flush", 1'b0, NOP, 2'd0);

        // Random traffic against a queue scoreboard.
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            logic [63:0] r;
            logic        fl, iv, ordy, exp_rdy;
            @(negedge clk);
            r    = {$urandom(), $urandom()};
            fl   = ($urandom_range(0, 31) == 0);
            iv   = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 2) != 0;
            drive(fl, iv, r[W-1:0], ordy);
            #1;
            exp_rdy = SKID ? ((q.size() < 2) && !fl) : ((q.size() == 0 || ordy) && !fl);
            chk("rand.in_ready", 64'(hs.in_ready), 64'(exp_rdy));
            if (hs.out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("rand.pop_empty", 64'd1, 64'd0);
                end else begin
                    chk("rand.pop_data", 64'(hs.out_data), 64'(q.pop_front()));
                end
            end
            if (fl) q.delete();
            if (iv && exp_rdy) q.push_back(r[W-1:0]);
            @(posedge clk);
            #1;
            chk("rand.occupancy", 64'(occupancy), 64'(q.size()));
            chk("rand.out_valid", 64'(hs.out_valid), 64'(q.size() != 0));
            chk("rand.out_data",  64'(hs.out_data),  64'((q.size() != 0) ? q[0] : NOP));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
